// File: rtl/mimodulo_seq.sv
// Self-checking stimulus sequencer for the two-input, two-output mimodulo block.
// Walks every input vector, holds each for HOLD cycles and logs mismatches against EXP1/EXP2.
module mimodulo_seq #(
  parameter int N_IN = 2,
  parameter int HOLD = 20,
  parameter logic [2**N_IN-1:0] EXP1 = 4'b1000,
  parameter logic [2**N_IN-1:0] EXP2 = 4'b1110
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [N_IN-1:0]      vec_out,
  input  logic                 dut_o1,
  input  logic                 dut_o2,
  output logic                 busy,
  output logic                 done,
  output logic [N_IN:0]        err_count,
  output logic [2**N_IN-1:0]   fail_vec
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0]      HOLD_LAST = 8'(HOLD - 1);
  localparam logic [N_IN-1:0] VEC_LAST  = '1;
  localparam logic [N_IN-1:0] VEC_ONE   = 1;
  localparam logic [N_IN:0]   ERR_ONE   = 1;

  state_t               state, state_n;
  logic [7:0]           cnt, cnt_n;
  logic [N_IN-1:0]      vec_n;
  logic                 busy_n, done_n;
  logic [N_IN:0]        err_n;
  logic [2**N_IN-1:0]   fail_n;
  logic                 mismatch;

  // DUT outputs are read combinationally; only the sample edge acts on this.
  assign mismatch = (dut_o1 != EXP1[vec_out]) || (dut_o2 != EXP2[vec_out]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      vec_out   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      vec_out   <= vec_n;
      busy      <= busy_n;
      done      <= done_n;
      err_count <= err_n;
      fail_vec  <= fail_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    vec_n   = vec_out;
    busy_n  = busy;
    done_n  = done;
    err_n   = err_count;
    fail_n  = fail_vec;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = APPLY;
          cnt_n   = '0;
          vec_n   = '0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          err_n   = '0;
          fail_n  = '0;
        end
      end

      APPLY: begin
        if (cnt == HOLD_LAST) begin
          if (mismatch) begin
            fail_n[vec_out] = 1'b1;
            err_n           = err_count + ERR_ONE;
          end
          cnt_n = '0;
          // The last vector finishes the run and parks vec_out back at zero.
          if (vec_out == VEC_LAST) begin
            state_n = DONE;
            vec_n   = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            vec_n = vec_out + VEC_ONE;
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mimodulo_seq.sv
// Scoreboard bench for mimodulo_seq: stimulus pushes expected run results, a monitor checks them at done.
// A second instance with HOLD=1 covers the one-vector-per-cycle case.
module tb_mimodulo_seq;

  localparam int HOLD0 = 20;
  localparam int HOLD1 = 1;
  localparam int NVEC  = 4;

  typedef struct {
    int done_edge;
    int err;
    int fail;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, start_h1;
  logic       fault;
  logic [1:0] vec, vec_h1;
  logic       o1, o2, o1_h1, o2_h1;
  logic       busy, done, busy_h1, done_h1;
  logic [2:0] err, err_h1;
  logic [3:0] fail, fail_h1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic prev_done0 = 1'b0;
  logic prev_done1 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference DUT: o1 = a&b (or a^b when faulted), o2 = a|b; a is the vector MSB.
  assign o1    = fault ? (vec[1] ^ vec[0]) : (vec[1] & vec[0]);
  assign o2    = vec[1] | vec[0];
  assign o1_h1 = vec_h1[1] & vec_h1[0];
  assign o2_h1 = vec_h1[1] | vec_h1[0];

  mimodulo_seq #(.N_IN(2), .HOLD(HOLD0), .EXP1(4'b1000), .EXP2(4'b1110)) dut (
    .clk(clk), .reset(reset), .start(start), .vec_out(vec),
    .dut_o1(o1), .dut_o2(o2), .busy(busy), .done(done),
    .err_count(err), .fail_vec(fail)
  );

  mimodulo_seq #(.N_IN(2), .HOLD(HOLD1), .EXP1(4'b1000), .EXP2(4'b1110)) dut_h1 (
    .clk(clk), .reset(reset), .start(start_h1), .vec_out(vec_h1),
    .dut_o1(o1_h1), .dut_o2(o2_h1), .busy(busy_h1), .done(done_h1),
    .err_count(err_h1), .fail_vec(fail_h1)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (edge %0d)", name, actual, expected, cyc);
    end
  endtask

  // Issues a start pulse and records when the run must finish and what it must report.
  task automatic applyStimulus(input int inst, input int e_err, input int e_fail);
    exp_t e;
    @(negedge clk);
    e.err  = e_err;
    e.fail = e_fail;
    if (inst == 0) begin
      start = 1'b1;
      e.done_edge = cyc + 1 + HOLD0 * NVEC;
      q0.push_back(e);
    end else begin
      start_h1 = 1'b1;
      e.done_edge = cyc + 1 + HOLD1 * NVEC;
      q1.push_back(e);
    end
    @(negedge clk);
    start    = 1'b0;
    start_h1 = 1'b0;
  endtask

  task automatic waitDone(input int inst, input int limit);
    int n = 0;
    while (((inst == 0) ? done : done_h1) !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (((inst == 0) ? done : done_h1) !== 1'b1)
      checkOutput("done_timeout", 0, 1);
  endtask

  // Follows the default instance through a whole run, optionally pulsing start mid-run.
  task automatic trackRun(input int pulse_at);
    for (int c = 0; c < HOLD0 * NVEC; c++) begin
      checkOutput("vec_seq", int'(vec), c / HOLD0);
      checkOutput("busy_run", int'(busy), 1);
      start = (c == pulse_at);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_vec"}, int'(vec), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_err"}, int'(err), 0);
    checkOutput({tag, "_fail"}, int'(fail), 0);
  endtask

  // Monitor: whenever an instance raises done, pop its expected result and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && prev_done0 !== 1'b1) begin
        if (q0.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          e = q0.pop_front();
          checkOutput("done_edge", cyc, e.done_edge);
          checkOutput("err_count", int'(err), e.err);
          checkOutput("fail_vec", int'(fail), e.fail);
          checkOutput("busy_at_done", int'(busy), 0);
        end
      end
      if (done_h1 === 1'b1 && prev_done1 !== 1'b1) begin
        if (q1.size() == 0) begin
          checkOutput("unexpected_done_h1", 1, 0);
        end else begin
          e = q1.pop_front();
          checkOutput("done_edge_h1", cyc, e.done_edge);
          checkOutput("err_count_h1", int'(err_h1), e.err);
          checkOutput("fail_vec_h1", int'(fail_h1), e.fail);
        end
      end
      prev_done0 = done;
      prev_done1 = done_h1;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    start_h1 = 1'b0;
    fault    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkIdle("reset");

    $display("[TB] correct DUT run");
    applyStimulus(0, 0, 0);
    trackRun(-1);
    waitDone(0, 5);
    checkOutput("busy_after", int'(busy), 0);
    checkOutput("vec_after", int'(vec), 0);

    $display("[TB] faulty DUT run");
    fault = 1'b1;
    applyStimulus(0, 3, 4'b1110);
    waitDone(0, 100);
    repeat (5) @(negedge clk);
    checkOutput("done_held", int'(done), 1);
    checkOutput("err_held", int'(err), 3);
    checkOutput("fail_held", int'(fail), 4'b1110);

    $display("[TB] restart from done");
    fault = 1'b0;
    applyStimulus(0, 0, 0);
    checkOutput("restart_done", int'(done), 0);
    checkOutput("restart_err", int'(err), 0);
    checkOutput("restart_fail", int'(fail), 0);
    checkOutput("restart_busy", int'(busy), 1);
    waitDone(0, 100);

    $display("[TB] start while busy");
    applyStimulus(0, 0, 0);
    trackRun(30);
    waitDone(0, 5);

    $display("[TB] reset mid-run");
    applyStimulus(0, 0, 0);
    repeat (44) @(negedge clk);
    checkOutput("vec_before_reset", int'(vec), 2);
    q0.delete();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkIdle("midreset");
    repeat (10) @(negedge clk);
    checkIdle("postreset");

    $display("[TB] reset together with start");
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    checkOutput("rst_start_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    checkOutput("rst_start_busy_later", int'(busy), 0);
    checkOutput("rst_start_vec", int'(vec), 0);

    $display("[TB] HOLD=1 run");
    applyStimulus(1, 0, 0);
    for (int c = 0; c < NVEC; c++) begin
      checkOutput("vec_h1_seq", int'(vec_h1), c);
      @(negedge clk);
    end
    waitDone(1, 5);

    repeat (2) @(negedge clk);
    checkOutput("pending_runs", q0.size(), 0);
    checkOutput("pending_runs_h1", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
